// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter with destination scoreboard.
// Optional starvation guard for port 1 is enabled with macro WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NR_REG       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [4:0]            p0_rd,
  input  logic [DATA_WIDTH-1:0] p0_data,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [4:0]            p1_rd,
  input  logic [DATA_WIDTH-1:0] p1_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [4:0]            iss_rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wrdata,
  output logic                  sb_err
);

  logic                  force_p1;
  logic                  p0_xfer, p1_xfer, iss_xfer;
  logic [NR_REG-1:0]     pending_q, pending_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [4:0]            rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wrdata_q, rf_wrdata_d;
  logic                  sb_err_q, sb_err_d;

  function automatic logic in_range(input logic [4:0] idx);
    return 32'(idx) < NR_REG;
  endfunction

  function automatic logic pend_at(input logic [NR_REG-1:0] vec, input logic [4:0] idx);
    return in_range(idx) ? vec[idx] : 1'b0;
  endfunction

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starve_q, starve_d;

  assign force_p1 = p1_valid && (starve_q == CntW'(STARVE_LIMIT));

  // Counts cycles port 1 has been kept waiting; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!p1_valid || p1_xfer) begin
      starve_d = '0;
    end else if (starve_q != CntW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_p1 = 1'b0;
`endif

  assign p0_ready  = !force_p1;
  assign p1_ready  = !p0_valid || force_p1;
  assign iss_ready = !pend_at(pending_q, iss_rd);
  assign rs1_busy  = pend_at(pending_q, rs1);
  assign rs2_busy  = pend_at(pending_q, rs2);

  // p0_ready and p1_ready are never both granted to valid requests in one cycle.
  assign p0_xfer  = p0_valid && p0_ready;
  assign p1_xfer  = p1_valid && p1_ready;
  assign iss_xfer = iss_valid && iss_ready;

  always_comb begin
    rf_wen_d    = 1'b0;
    rf_rd_d     = '0;
    rf_wrdata_d = '0;
    if (p0_xfer) begin
      if (p0_rd != '0) begin
        rf_wen_d    = 1'b1;
        rf_rd_d     = p0_rd;
        rf_wrdata_d = p0_data;
      end
    end else if (p1_xfer) begin
      if (p1_rd != '0) begin
        rf_wen_d    = 1'b1;
        rf_rd_d     = p1_rd;
        rf_wrdata_d = p1_data;
      end
    end
  end

  // Issue set is applied after the completion clear so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (p1_xfer && in_range(p1_rd)) begin
      pending_d[p1_rd] = 1'b0;
    end
    if (iss_xfer && (iss_rd != '0) && in_range(iss_rd)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  assign sb_err_d = sb_err_q ||
                    (p1_xfer && (p1_rd != '0) && !pend_at(pending_q, p1_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q    <= 1'b0;
      rf_rd_q     <= '0;
      rf_wrdata_q <= '0;
      pending_q   <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      rf_wen_q    <= rf_wen_d;
      rf_rd_q     <= rf_rd_d;
      rf_wrdata_q <= rf_wrdata_d;
      pending_q   <= pending_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wrdata = rf_wrdata_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p0_ready;
  logic [4:0]  p0_rd;
  logic [31:0] p0_data;
  logic        p1_valid, p1_ready;
  logic [4:0]  p1_rd;
  logic [31:0] p1_data;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wrdata;
  logic        sb_err;

  int n_total = 0;
  int n_pass  = 0;

  wb_arbiter #(
    .DATA_WIDTH  (32),
    .NR_REG      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_valid (p0_valid),
    .p0_ready (p0_ready),
    .p0_rd    (p0_rd),
    .p0_data  (p0_data),
    .p1_valid (p1_valid),
    .p1_ready (p1_ready),
    .p1_rd    (p1_rd),
    .p1_data  (p1_data),
    .iss_valid(iss_valid),
    .iss_ready(iss_ready),
    .iss_rd   (iss_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rf_wen   (rf_wen),
    .rf_rd    (rf_rd),
    .rf_wrdata(rf_wrdata),
    .sb_err   (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p0v;
    logic [4:0]  p0rd;
    logic [31:0] p0d;
    logic        p1v;
    logic [4:0]  p1rd;
    logic [31:0] p1d;
    logic        e_p1rdy;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    p0_valid  = 1'b0;
    p1_valid  = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic exp_p1;
`ifdef WB_STARVE_GUARD_EN
    logic guard = 1'b1;
`else
    logic guard = 1'b0;
`endif
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd3,  32'h11111111, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h55,   1'b1, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd3, 32'h3333, 1'b0, 1'b1, 5'd31, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 5'd1,  32'h00000001, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 5'd1,  32'h00000001};

    rst_n = 1'b0;
    idle();
    p0_rd = '0; p0_data = '0; p1_rd = '0; p1_data = '0;
    iss_rd = '0; rs1 = 5'd0; rs2 = 5'd0;
    #2;
    chk1("reset rf_wen", rf_wen, 1'b0);
    chk("reset rf_rd", 32'(rf_rd), 32'd0);
    chk("reset rf_wrdata", rf_wrdata, 32'd0);
    chk1("reset sb_err", sb_err, 1'b0);
    chk1("reset p0_ready", p0_ready, 1'b1);
    chk1("reset iss_ready", iss_ready, 1'b1);
    p0_valid = 1'b1;
    #1;
    chk1("reset p1_ready with p0_valid", p1_ready, 1'b0);
    p0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) begin
      p0_valid = vecs[i].p0v; p0_rd = vecs[i].p0rd; p0_data = vecs[i].p0d;
      p1_valid = vecs[i].p1v; p1_rd = vecs[i].p1rd; p1_data = vecs[i].p1d;
      #1;
      chk1($sformatf("vec%0d p0_ready", i), p0_ready, 1'b1);
      chk1($sformatf("vec%0d p1_ready", i), p1_ready, vecs[i].e_p1rdy);
      cycle();
      chk1($sformatf("vec%0d rf_wen", i), rf_wen, vecs[i].e_wen);
      chk($sformatf("vec%0d rf_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d rf_wrdata", i), rf_wrdata, vecs[i].e_d);
    end
    idle();
    cycle();

    // Starvation: reserve reg 4 so the eventual p1 write is legal.
    iss_valid = 1'b1; iss_rd = 5'd4;
    cycle();
    iss_valid = 1'b0;
    p0_valid = 1'b1; p0_rd = 5'd2;
    p1_valid = 1'b1; p1_rd = 5'd4; p1_data = 32'h77;
    for (int k = 1; k <= 6; k++) begin
      p0_data = 32'(k);
      exp_p1  = guard && (k == 5);
      #1;
      chk1($sformatf("starve%0d p1_ready", k), p1_ready, exp_p1);
      chk1($sformatf("starve%0d p0_ready", k), p0_ready, !exp_p1);
      cycle();
      chk($sformatf("starve%0d rf_rd", k), 32'(rf_rd), exp_p1 ? 32'd4 : 32'd2);
      chk($sformatf("starve%0d rf_wrdata", k), rf_wrdata, exp_p1 ? 32'h77 : 32'(k));
    end
    idle();
    rs1 = 5'd4;
    cycle();
    chk1("starve reg4 busy", rs1_busy, !guard);
    chk1("starve sb_err", sb_err, 1'b0);

    // Scoreboard reserve, WAW stall and release.
    rs1 = 5'd7; rs2 = 5'd8;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    chk1("iss7 iss_ready", iss_ready, 1'b1);
    chk1("iss7 rs1_busy before", rs1_busy, 1'b0);
    cycle();
    chk1("iss7 rs1_busy", rs1_busy, 1'b1);
    chk1("iss7 rs2_busy", rs2_busy, 1'b0);
    chk1("iss7 second iss_ready", iss_ready, 1'b0);
    iss_valid = 1'b0;
    p1_valid = 1'b1; p1_rd = 5'd7; p1_data = 32'hCAFE0007;
    #1;
    chk1("p1w7 p1_ready", p1_ready, 1'b1);
    cycle();
    p1_valid = 1'b0;
    chk1("p1w7 rs1_busy", rs1_busy, 1'b0);
    chk1("p1w7 rf_wen", rf_wen, 1'b1);
    chk("p1w7 rf_rd", 32'(rf_rd), 32'd7);
    chk("p1w7 rf_wrdata", rf_wrdata, 32'hCAFE0007);
    chk1("p1w7 iss_ready", iss_ready, 1'b1);
    chk1("p1w7 sb_err", sb_err, 1'b0);

    // rd==0 consumed silently, then an unreserved p1 write with a same-cycle issue.
    p0_valid = 1'b1; p0_rd = 5'd0; p0_data = 32'h1234;
    cycle();
    p0_valid = 1'b0;
    chk1("rd0 rf_wen", rf_wen, 1'b0);
    chk("rd0 rf_wrdata", rf_wrdata, 32'd0);
    rs1 = 5'd9;
    p1_valid = 1'b1; p1_rd = 5'd9; p1_data = 32'h99;
    iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    idle();
    chk1("sberr set", sb_err, 1'b1);
    chk1("sberr write done", rf_wen, 1'b1);
    chk("sberr rf_rd", 32'(rf_rd), 32'd9);
    chk1("sberr set wins reg9", rs1_busy, 1'b1);
    repeat (3) cycle();
    chk1("sberr sticky", sb_err, 1'b1);
    chk1("sberr idle rf_wen", rf_wen, 1'b0);

    // Reset while a write sits in the output stage.
    p0_valid = 1'b1; p0_rd = 5'd12; p0_data = 32'hBEEF;
    cycle();
    p0_valid = 1'b0;
    chk1("midrst staged wen", rf_wen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst rf_wen", rf_wen, 1'b0);
    chk("midrst rf_rd", 32'(rf_rd), 32'd0);
    chk("midrst rf_wrdata", rf_wrdata, 32'd0);
    chk1("midrst sb_err", sb_err, 1'b0);
    chk1("midrst pending cleared", rs1_busy, 1'b0);
    chk1("midrst iss_ready", iss_ready, 1'b1);
    p0_valid = 1'b1;
    #1;
    chk1("midrst p0_ready", p0_ready, 1'b1);
    chk1("midrst p1_ready", p1_ready, 1'b0);
    p0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk1("postrst rf_wen 1", rf_wen, 1'b0);
    cycle();
    chk1("postrst rf_wen 2", rf_wen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
